// File: rtl/ivector_say_arbiter.sv
// ivector_say_arbiter
//   Round-robin arbiter and flow scheduler in front of IVector. Shares the
//   single `say` method among NREQ requesters, bounds the number of `say`
//   transfers not yet answered by `heard` to MAX_OUT, drives the IVector
//   respond-rule enable and offers a flush handshake that drains the path.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   MAX_OUT  maximum in-flight transfers (1..15)
//
// Ports
//   CLK, nRST                     clock (rising edge), async active-low reset
//   req_say__ENA/meth/v           per-requester request and payload (32b each,
//                                 requester i at bits [32i+31:32i])
//   req_say__RDY                  one-hot grant, combinational
//   say__ENA/meth/v, say__RDY     muxed transfer towards IVector
//   heard__ENA, heard__RDY        answer indication from IVector (RDY tied 1)
//   rule_enable, rule_ready       IVector respond-rule handshake
//   flush__ENA, flush__RDY        drain request, accepted while running
//   flush_done                    one-cycle pulse when the drain completes
//   outstanding                   current in-flight count
//   err_underflow                 sticky, `heard` seen with nothing in flight
//
// Optional feature (macro IVECTOR_ARB_STATS_EN)
//   Adds saturating 16-bit counters stat_grants (transfers) and stat_stalls
//   (cycles with a request pending but no transfer).

module ivector_say_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NREQ-1:0]     req_say__ENA,
  input  logic [32*NREQ-1:0]  req_say_meth,
  input  logic [32*NREQ-1:0]  req_say_v,
  output logic [NREQ-1:0]     req_say__RDY,
  output logic                say__ENA,
  output logic [31:0]         say_meth,
  output logic [31:0]         say_v,
  input  logic                say__RDY,
  input  logic                heard__ENA,
  output logic                heard__RDY,
  output logic                rule_enable,
  input  logic                rule_ready,
  input  logic                flush__ENA,
  output logic                flush__RDY,
  output logic                flush_done,
  output logic [3:0]          outstanding,
  output logic                err_underflow
`ifdef IVECTOR_ARB_STATS_EN
  ,
  output logic [15:0]         stat_grants,
  output logic [15:0]         stat_stalls
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   ptr_next;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   cand;
  logic [3:0]      outstanding_reg;
  logic            err_underflow_reg;
  logic            flush_done_reg;
  logic            can_grant;
  logic            found;
  logic            transfer;
  logic [NREQ-1:0] eligible;

  // Grants need the RUN state, a ready IVector and a free credit.
  assign can_grant = (state_reg == ST_RUN) && say__RDY && (outstanding_reg < MAX_OUT_C);
  assign eligible  = req_say__ENA & {NREQ{can_grant}};

  // Round-robin scan starting at ptr_reg; first eligible index wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_reg) + k) % NREQ);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign req_say__RDY[gi] = found && (winner == PW'(gi));
  end

  assign say__ENA = |(req_say__ENA & req_say__RDY);
  assign transfer = say__ENA;
  assign ptr_next = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);

  // AND-OR payload mux; yields zero when nothing is granted.
  always_comb begin
    say_meth = '0;
    say_v    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_say__RDY[i]) begin
        say_meth = say_meth | req_say_meth[32*i +: 32];
        say_v    = say_v | req_say_v[32*i +: 32];
      end
    end
  end

  assign heard__RDY    = 1'b1;
  assign rule_enable   = rule_ready && (outstanding_reg != 4'd0);
  assign flush__RDY    = (state_reg == ST_RUN);
  assign flush_done    = flush_done_reg;
  assign outstanding   = outstanding_reg;
  assign err_underflow = err_underflow_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg         <= ST_RUN;
      ptr_reg           <= '0;
      outstanding_reg   <= 4'd0;
      err_underflow_reg <= 1'b0;
      flush_done_reg    <= 1'b0;
    end else begin
      if (transfer) begin
        ptr_reg <= ptr_next;
      end

      // A transfer and a heard in the same cycle cancel out.
      if (transfer && !heard__ENA) begin
        outstanding_reg <= outstanding_reg + 4'd1;
      end else if (heard__ENA && !transfer && (outstanding_reg != 4'd0)) begin
        outstanding_reg <= outstanding_reg - 4'd1;
      end

      if (heard__ENA && (outstanding_reg == 4'd0)) begin
        err_underflow_reg <= 1'b1;
      end

      flush_done_reg <= 1'b0;
      case (state_reg)
        ST_RUN: begin
          if (flush__ENA) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (outstanding_reg == 4'd0) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg      <= ST_RUN;
          flush_done_reg <= 1'b1;
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

`ifdef IVECTOR_ARB_STATS_EN
  logic [15:0] stat_grants_reg;
  logic [15:0] stat_stalls_reg;
  logic        stall;

  assign stall       = (|req_say__ENA) && !transfer;
  assign stat_grants = stat_grants_reg;
  assign stat_stalls = stat_stalls_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_grants_reg <= 16'd0;
      stat_stalls_reg <= 16'd0;
    end else begin
      if (transfer && (stat_grants_reg != 16'hFFFF)) begin
        stat_grants_reg <= stat_grants_reg + 16'd1;
      end
      if (stall && (stat_stalls_reg != 16'hFFFF)) begin
        stat_stalls_reg <= stat_stalls_reg + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ivector_say_arbiter.sv
// Testbench for ivector_say_arbiter (NREQ=4, MAX_OUT=8).
// Table of per-cycle vectors followed by hand-written multi-cycle sequences:
// credit limit, flush with traffic in flight, async reset during drain and,
// when IVECTOR_ARB_STATS_EN is defined, the statistics counters.

module tb_ivector_say_arbiter;

  logic         CLK;
  logic         nRST;
  logic [3:0]   req_say__ENA;
  logic [127:0] req_say_meth;
  logic [127:0] req_say_v;
  logic [3:0]   req_say__RDY;
  logic         say__ENA;
  logic [31:0]  say_meth;
  logic [31:0]  say_v;
  logic         say__RDY;
  logic         heard__ENA;
  logic         heard__RDY;
  logic         rule_enable;
  logic         rule_ready;
  logic         flush__ENA;
  logic         flush__RDY;
  logic         flush_done;
  logic [3:0]   outstanding;
  logic         err_underflow;
`ifdef IVECTOR_ARB_STATS_EN
  logic [15:0]  stat_grants;
  logic [15:0]  stat_stalls;
`endif

  int errors = 0;
  int checks = 0;

  ivector_say_arbiter #(.NREQ(4), .MAX_OUT(8)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req_say__ENA (req_say__ENA),
    .req_say_meth (req_say_meth),
    .req_say_v    (req_say_v),
    .req_say__RDY (req_say__RDY),
    .say__ENA     (say__ENA),
    .say_meth     (say_meth),
    .say_v        (say_v),
    .say__RDY     (say__RDY),
    .heard__ENA   (heard__ENA),
    .heard__RDY   (heard__RDY),
    .rule_enable  (rule_enable),
    .rule_ready   (rule_ready),
    .flush__ENA   (flush__ENA),
    .flush__RDY   (flush__RDY),
    .flush_done   (flush_done),
    .outstanding  (outstanding),
    .err_underflow(err_underflow)
`ifdef IVECTOR_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_stalls  (stat_stalls)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] ena;
    logic       srdy;
    logic       heard;
    logic       flush;
    logic       rready;
    logic [3:0] rdy;
    logic [3:0] outs;
    logic       rule;
    logic       frdy;
    logic       fdone;
    logic       err;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    req_say__ENA = 4'b0;
    say__RDY     = 1'b0;
    heard__ENA   = 1'b0;
    rule_ready   = 1'b0;
    flush__ENA   = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // Expected payload of a granted requester, derived from the expected grant.
  function automatic logic [31:0] exp_word(input logic [3:0] onehot, input logic [31:0] base);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (onehot[i]) w = base + 32'(i);
    end
    return w;
  endfunction

  int fdone_cnt;
  int sends;

  initial begin
    nRST = 1'b0;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      req_say_meth[32*i +: 32] = 32'h100 + 32'(i);
      req_say_v[32*i +: 32]    = 32'h200 + 32'(i);
    end

    //            ena   srdy  heard flush rrdy  rdy      outs  rule  frdy  fdone err
    vecs[0]  = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[22] = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    reset_dut();
    @(negedge CLK);
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    chk("reset_err", 32'(err_underflow), 32'd0);
    chk("reset_fdone", 32'(flush_done), 32'd0);
    chk("reset_frdy", 32'(flush__RDY), 32'd1);
    chk("reset_say_ena", 32'(say__ENA), 32'd0);
    chk("reset_rdy", 32'(req_say__RDY), 32'd0);
    chk("heard_rdy", 32'(heard__RDY), 32'd1);
    tick();

    // Per-cycle vector table
    for (int v = 0; v < 23; v++) begin
      req_say__ENA = vecs[v].ena;
      say__RDY     = vecs[v].srdy;
      heard__ENA   = vecs[v].heard;
      flush__ENA   = vecs[v].flush;
      rule_ready   = vecs[v].rready;
      @(negedge CLK);
      $display("vec %0d: ena=%b rdy=%b say=%b meth=%0h out=%0d rule=%b frdy=%b fdone=%b err=%b",
               v, req_say__ENA, req_say__RDY, say__ENA, say_meth, outstanding,
               rule_enable, flush__RDY, flush_done, err_underflow);
      chk($sformatf("vec%0d_rdy", v), 32'(req_say__RDY), 32'(vecs[v].rdy));
      chk($sformatf("vec%0d_say_ena", v), 32'(say__ENA), 32'(|vecs[v].rdy));
      chk($sformatf("vec%0d_meth", v), say_meth, exp_word(vecs[v].rdy, 32'h100));
      chk($sformatf("vec%0d_v", v), say_v, exp_word(vecs[v].rdy, 32'h200));
      chk($sformatf("vec%0d_out", v), 32'(outstanding), 32'(vecs[v].outs));
      chk($sformatf("vec%0d_rule", v), 32'(rule_enable), 32'(vecs[v].rule));
      chk($sformatf("vec%0d_frdy", v), 32'(flush__RDY), 32'(vecs[v].frdy));
      chk($sformatf("vec%0d_fdone", v), 32'(flush_done), 32'(vecs[v].fdone));
      chk($sformatf("vec%0d_err", v), 32'(err_underflow), 32'(vecs[v].err));
      tick();
    end
`ifdef IVECTOR_ARB_STATS_EN
    chk("stat_grants_table", 32'(stat_grants), 32'd10);
    chk("stat_stalls_table", 32'(stat_stalls), 32'd4);
`endif

    // Credit limit: requester 2 alone, no heard
    reset_dut();
    chk("credit_err_cleared", 32'(err_underflow), 32'd0);
    req_say__ENA = 4'b0100;
    say__RDY     = 1'b1;
    sends = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk($sformatf("credit_rdy%0d", i), 32'(req_say__RDY), 32'b0100);
      if (say__ENA) sends++;
      tick();
    end
    @(negedge CLK);
    $display("credit: sends=%0d out=%0d rdy=%b", sends, outstanding, req_say__RDY);
    chk("credit_sends", 32'(sends), 32'd8);
    chk("credit_full_rdy", 32'(req_say__RDY), 32'd0);
    chk("credit_full_out", 32'(outstanding), 32'd8);
    tick();
    heard__ENA = 1'b1;
    @(negedge CLK);
    chk("credit_heard_same_cycle_rdy", 32'(req_say__RDY), 32'd0);
    tick();
    heard__ENA = 1'b0;
    @(negedge CLK);
    $display("credit after heard: out=%0d rdy=%b", outstanding, req_say__RDY);
    chk("credit_after_heard_out", 32'(outstanding), 32'd7);
    chk("credit_after_heard_rdy", 32'(req_say__RDY), 32'b0100);
    chk("credit_after_heard_say", 32'(say__ENA), 32'd1);
    tick();
    @(negedge CLK);
    chk("credit_refull_out", 32'(outstanding), 32'd8);
    chk("credit_refull_rdy", 32'(req_say__RDY), 32'd0);

    // Flush with 5 in flight
    reset_dut();
    req_say__ENA = 4'b0001;
    say__RDY     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("flush_fill%0d", i), 32'(req_say__RDY), 32'b0001);
      tick();
    end
    flush__ENA = 1'b1;
    @(negedge CLK);
    chk("flush_accept_frdy", 32'(flush__RDY), 32'd1);
    chk("flush_accept_grant", 32'(req_say__RDY), 32'b0001);
    chk("flush_accept_out", 32'(outstanding), 32'd4);
    tick();
    flush__ENA = 1'b0;
    rule_ready = 1'b1;
    @(negedge CLK);
    $display("flush drain: out=%0d rdy=%b frdy=%b rule=%b", outstanding, req_say__RDY, flush__RDY, rule_enable);
    chk("flush_drain_rdy", 32'(req_say__RDY), 32'd0);
    chk("flush_drain_out", 32'(outstanding), 32'd5);
    chk("flush_drain_frdy", 32'(flush__RDY), 32'd0);
    chk("flush_drain_rule_hi", 32'(rule_enable), 32'd1);
    tick();
    rule_ready = 1'b0;
    @(negedge CLK);
    chk("flush_drain_rule_lo", 32'(rule_enable), 32'd0);
    tick();
    fdone_cnt  = 0;
    heard__ENA = 1'b1;
    rule_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("flush_heard_out%0d", i), 32'(outstanding), 32'(5 - i));
      chk($sformatf("flush_heard_rdy%0d", i), 32'(req_say__RDY), 32'd0);
      if (flush_done) fdone_cnt++;
      tick();
    end
    heard__ENA = 1'b0;
    @(negedge CLK);
    chk("flush_x1_out", 32'(outstanding), 32'd0);
    chk("flush_x1_fdone", 32'(flush_done), 32'd0);
    chk("flush_x1_rule", 32'(rule_enable), 32'd0);
    if (flush_done) fdone_cnt++;
    tick();
    @(negedge CLK);
    chk("flush_x2_fdone", 32'(flush_done), 32'd0);
    chk("flush_x2_rdy", 32'(req_say__RDY), 32'd0);
    if (flush_done) fdone_cnt++;
    tick();
    @(negedge CLK);
    $display("flush done: fdone=%b frdy=%b rdy=%b", flush_done, flush__RDY, req_say__RDY);
    chk("flush_x3_fdone", 32'(flush_done), 32'd1);
    chk("flush_x3_frdy", 32'(flush__RDY), 32'd1);
    chk("flush_x3_rdy", 32'(req_say__RDY), 32'b0001);
    if (flush_done) fdone_cnt++;
    tick();
    @(negedge CLK);
    chk("flush_x4_fdone", 32'(flush_done), 32'd0);
    if (flush_done) fdone_cnt++;
    chk("flush_pulse_count", 32'(fdone_cnt), 32'd1);

    // Async reset in the middle of a drain
    reset_dut();
    req_say__ENA = 4'b0010;
    say__RDY     = 1'b1;
    tick();
    tick();
    flush__ENA = 1'b1;
    tick();
    flush__ENA = 1'b0;
    heard__ENA = 1'b1;
    #2;
    chk("areset_pre_out", 32'(outstanding), 32'd3);
    chk("areset_pre_frdy", 32'(flush__RDY), 32'd0);
    nRST = 1'b0;
    #1;
    $display("async reset: out=%0d frdy=%b fdone=%b", outstanding, flush__RDY, flush_done);
    chk("areset_out", 32'(outstanding), 32'd0);
    chk("areset_frdy", 32'(flush__RDY), 32'd1);
    chk("areset_fdone", 32'(flush_done), 32'd0);
    chk("areset_err", 32'(err_underflow), 32'd0);
    heard__ENA   = 1'b0;
    req_say__ENA = 4'b0;
    @(negedge CLK);
    nRST = 1'b1;
    fdone_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (flush_done) fdone_cnt++;
    end
    chk("areset_no_fdone", 32'(fdone_cnt), 32'd0);

`ifdef IVECTOR_ARB_STATS_EN
    // Stall counter saturation
    reset_dut();
    req_say__ENA = 4'hF;
    say__RDY     = 1'b0;
    repeat (70000) @(posedge CLK);
    #1;
    @(negedge CLK);
    $display("stats: grants=%0h stalls=%0h", stat_grants, stat_stalls);
    chk("stat_stalls_sat", 32'(stat_stalls), 32'hFFFF);
    chk("stat_grants_zero", 32'(stat_grants), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ivector_say_arbiter.md
# ivector_say_arbiter

Round-robin arbiter and flow scheduler placed in front of the IVector block. It shares the single `say` method among NREQ requesters and bounds the number of requests in flight to IVector. It also drives IVector's `respond` rule enable and provides a flush handshake that quiesces the path. In-flight count is tracked from `say` transfers minus `heard` indications.

## Interface
- NREQ, 4, number of requesters (2..8)
- MAX_OUT, 8, maximum outstanding `say` transfers not yet answered by `heard` (1..15)
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  reset, asynchronous, active-low
- req_say__ENA  in  NREQ  per-requester request valid
- req_say_meth  in  32*NREQ  per-requester meth, requester i at bits [32i+31:32i]
- req_say_v  in  32*NREQ  per-requester v, same packing
- req_say__RDY  out  NREQ  one-hot grant; requester i transfers when ENA[i]&RDY[i]
- say__ENA  out  1  to IVector `say`
- say_meth, say_v  out  32 each  muxed payload of granted requester
- say__RDY  in  1  IVector `say` ready
- heard__ENA  in  1  IVector `heard` indication fired
- heard__RDY  out  1  constant 1
- rule_enable  out  1  IVector respond-rule enable
- rule_ready  in  1  IVector respond-rule ready
- flush__ENA  in  1  request drain; accepted when flush__RDY
- flush__RDY  out  1  high in RUN
- flush_done  out  1  one-cycle pulse, drain complete
- outstanding  out  4  current in-flight count
- err_underflow  out  1  sticky, `heard` while outstanding==0

## Operation
- Eligible = req_say__ENA & (state==RUN) & say__RDY & (outstanding<MAX_OUT).
- Winner = first eligible index scanning ptr, ptr+1, … mod NREQ. req_say__RDY = onehot(winner) when any eligible, else 0. This is combinational.
- say__ENA = |(req_say__ENA & req_say__RDY). The payload is the winner's, or 0 when say__ENA=0.
- On a transfer, ptr <= (winner+1) mod NREQ. ptr holds otherwise.
- outstanding: +1 on a transfer, -1 on heard__ENA, unchanged when both occur. It never exceeds MAX_OUT.
- heard__ENA with outstanding==0: count stays 0 and err_underflow sets. It clears only on reset.
- rule_enable = rule_ready & (outstanding!=0).
- FSM:
  - RUN: grants allowed. flush__ENA moves to DRAIN.
  - DRAIN: no grants. rule_enable still active. Moves to DONE when outstanding==0, checked on the registered value.
  - DONE: flush_done=1 for one cycle, then RUN.
- flush__ENA is ignored outside RUN. A transfer in the cycle flush__ENA is accepted still counts.

## Timing
- Reset values: ptr=0, outstanding=0, state=RUN, err_underflow=0, flush_done=0, stats counters 0.
- Combinational outputs follow inputs in the same cycle: say__ENA, req_say__RDY, payload, rule_enable, flush__RDY.
- Grant-to-say latency is 0 cycles. Counter and pointer updates are visible the next cycle.
- Full boundary: when outstanding==MAX_OUT, all req_say__RDY are 0. A heard in that cycle re-enables grants the next cycle, not the same cycle.
- Flush with outstanding==0: DRAIN for 1 cycle, then DONE. flush_done appears 2 cycles after the accepting edge.
- When nRST is asserted mid-drain, return immediately to RUN with no flush_done. In-flight requests are forgotten.

## Configuration
- IVECTOR_ARB_STATS_EN defined adds two outputs:
  - stat_grants [15:0]: counts transfers.
  - stat_stalls [15:0]: counts cycles with any req_say__ENA set and no transfer.
  - Both saturate at 0xFFFF and reset to 0.
- IVECTOR_ARB_STATS_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Fairness: all 4 requesters held high with say__RDY=1 and heard__ENA pulsed each cycle. Grants go 0,1,2,3,0…; say_meth equals each requester's meth.
- Credit limit: MAX_OUT=8, requester 2 always requesting, no heard. Exactly 8 transfers, then RDY=0 and outstanding=8. One heard pulse gives outstanding=7 and a transfer on the following cycle.
- Simultaneous transfer and heard at outstanding=3: stays 3.
- Underflow: heard__ENA with outstanding=0 gives err_underflow=1 and outstanding=0. err_underflow stays set until nRST.
- Flush with 5 in flight:
  - Grants stop the cycle after acceptance.
  - rule_enable follows rule_ready.
  - After 5 heards, flush_done pulses once, then RUN resumes.
- Async reset mid-DRAIN: nRST low between edges immediately zeroes outstanding and sets state=RUN, and flush_done stays 0. With STATS_EN, 70000 stalled cycles leave stat_stalls=0xFFFF.
